board_draw_seq: RTL and testbench

Frame sequencer that sits directly upstream of the 24x24 cell box drawer. On a `go` request it walks the Tetris playfield one cell at a time in row-major order and reads each cell's piece code from the board RAM. It maps the code to a 9-bit RRR_GGG_BBB colour and issues one box-draw command per cell, waiting for the drawer's `done` before moving to the next cell. It pulses `frame_done` once the whole playfield has been redrawn.

---
 rtl/board_draw_if.sv | 24 ++
 rtl/board_draw_seq.sv | 79 +++++++
 tb/tb_board_draw_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/board_draw_if.sv
// board_draw_if: groups the sequencer's board-RAM read port, box-drawer command port and frame control.
interface board_draw_if;
    logic       go;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [2:0] rd_data;
    logic       box_start;
    logic [9:0] box_x0;
    logic [8:0] box_y0;
    logic [8:0] box_color;
    logic       box_done;
    logic       busy;
    logic       frame_done;

    modport master (
        input  go, rd_data, box_done,
        output rd_en, rd_addr, box_start, box_x0, box_y0, box_color, busy, frame_done
    );

    modport slave (
        output go, rd_data, box_done,
        input  rd_en, rd_addr, box_start, box_x0, box_y0, box_color, busy, frame_done
    );
endinterface

// File: rtl/board_draw_seq.sv
// board_draw_seq: walks the playfield row-major, reads each cell's piece code and
// issues one coloured box-draw command per cell, pulsing frame_done at the end.
module board_draw_seq #(
    parameter int         COLS        = 10,
    parameter int         ROWS        = 20,
    parameter int         CELL        = 24,
    parameter int         ORIGIN_X    = 200,
    parameter int         ORIGIN_Y    = 0,
    parameter logic [8:0] EMPTY_COLOR = 9'h000
) (
    input logic          CLOCK_50,
    input logic          resetn,
    board_draw_if.master bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [7:0][8:0] PAL = {9'o740, 9'o007, 9'o700, 9'o070, 9'o507, 9'o770, 9'o077, EMPTY_COLOR};

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, FINISH} state_t;

    state_t        state, next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last;

    assign last           = col == CW'(COLS - 1) && row == RW'(ROWS - 1);
    assign bus.rd_en      = state == FETCH;
    assign bus.box_start  = state == ISSUE;
    assign bus.busy       = state inside {FETCH, LATCH, ISSUE, WAIT};
    assign bus.frame_done = state == FINISH;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.go ? FETCH : IDLE;
            FETCH:   next = LATCH;
            LATCH:   next = ISSUE;
            ISSUE:   next = WAIT;
            WAIT:    next = !bus.box_done ? WAIT : last ? FINISH : FETCH;
            default: next = IDLE;
        endcase
    end

    // Position is tracked by accumulators; x wraps to the origin at each row end.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            col           <= '0;
            row           <= '0;
            bus.rd_addr   <= '0;
            bus.box_color <= '0;
            bus.box_x0    <= 10'(ORIGIN_X);
            bus.box_y0    <= 9'(ORIGIN_Y);
        end else if (state == IDLE && bus.go) begin
            col         <= '0;
            row         <= '0;
            bus.rd_addr <= '0;
            bus.box_x0  <= 10'(ORIGIN_X);
            bus.box_y0  <= 9'(ORIGIN_Y);
        end else if (state == LATCH) begin
            bus.box_color <= PAL[bus.rd_data];
        end else if (state == WAIT && bus.box_done && !last) begin
            bus.rd_addr <= bus.rd_addr + 8'd1;
            if (col != CW'(COLS - 1)) begin
                col        <= col + CW'(1);
                bus.box_x0 <= bus.box_x0 + 10'(CELL);
            end else begin
                col        <= '0;
                row        <= row + RW'(1);
                bus.box_x0 <= 10'(ORIGIN_X);
                bus.box_y0 <= bus.box_y0 + 9'(CELL);
            end
        end
    end
endmodule

// File: tb/tb_board_draw_seq.sv
// tb_board_draw_seq: random boards and drawer latencies checked against a
// coordinate/palette model of the expected per-cell command list.
module tb_board_draw_seq;
    localparam int COLS = 10, ROWS = 20, CELL = 24, OX = 200, OY = 0, N = COLS * ROWS;
    localparam logic [8:0] EMPTY = 9'h000;

    logic CLOCK_50 = 0;
    logic resetn = 0;
    logic go_main = 0, go_inj = 0, stray = 0, done_q = 0, inject = 0;
    logic [2:0] board [N];
    int lat = 5, dcnt = 0, fd_cnt = 0, n_chk = 0, n_fail = 0;
    int q_x[$], q_y[$], q_c[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    board_draw_if bus ();
    assign bus.go       = go_main | go_inj;
    assign bus.box_done = done_q | stray;

    board_draw_seq #(.COLS(COLS), .ROWS(ROWS), .CELL(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY),
                     .EMPTY_COLOR(EMPTY)) dut (.CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus));

    function automatic int pal(int code);
        int p [8];
        p = '{int'(EMPTY), 'o077, 'o770, 'o507, 'o070, 'o700, 'o007, 'o740};
        return p[code];
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50) if (bus.rd_en) bus.rd_data <= board[bus.rd_addr];

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            dcnt   <= 0;
            done_q <= 0;
        end else begin
            done_q <= dcnt == 1;
            dcnt   <= bus.box_start ? lat : (dcnt > 0 ? dcnt - 1 : 0);
        end
    end

    always @(negedge CLOCK_50) begin
        if (bus.box_start) begin
            q_x.push_back(int'(bus.box_x0));
            q_y.push_back(int'(bus.box_y0));
            q_c.push_back(int'(bus.box_color));
        end
        if (bus.frame_done) fd_cnt++;
        if (done_q && q_x.size() > 0) begin
            check("hold_x", bus.box_x0, q_x[$]);
            check("hold_c", bus.box_color, q_c[$]);
        end
        go_inj = inject && bus.busy && $urandom_range(0, 3) == 0;
        stray  = inject && bus.rd_en && $urandom_range(0, 1) == 0;
    end

    task automatic start_frame(int l);
        lat = l;
        q_x.delete(); q_y.delete(); q_c.delete();
        @(negedge CLOCK_50) go_main = 1;
        @(negedge CLOCK_50) go_main = 0;
        check("go_rd_en", bus.rd_en, 1);
        check("go_rd_addr", bus.rd_addr, 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("go_box_start", bus.box_start, 1);
        check("go_color", bus.box_color, pal(int'(board[0])));
    endtask

    task automatic run_frame(int l);
        int fd0;
        fd0 = fd_cnt;
        start_frame(l);
        for (int i = 0; i < 20000 && fd_cnt == fd0; i++) @(negedge CLOCK_50);
        check("frame_done", fd_cnt - fd0, 1);
        @(negedge CLOCK_50);
        check("busy_after", bus.busy, 0);
        check("frame_once", fd_cnt - fd0, 1);
        check("n_starts", q_x.size(), N);
        for (int i = 0; i < N && i < q_x.size(); i++) begin
            check($sformatf("x[%0d]", i), q_x[i], OX + (i % COLS) * CELL);
            check($sformatf("y[%0d]", i), q_y[i], OY + (i / COLS) * CELL);
            check($sformatf("c[%0d]", i), q_c[i], pal(int'(board[i])));
        end
    endtask

    initial begin
        foreach (board[i]) board[i] = 0;
        go_main = 1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.box_start, 0);
        check("rst_fd", bus.frame_done, 0);
        check("rst_addr", bus.rd_addr, 0);
        check("rst_color", bus.box_color, 0);
        check("rst_x0", bus.box_x0, OX);
        check("rst_y0", bus.box_y0, OY);
        go_main = 0;
        resetn = 1;
        @(negedge CLOCK_50);

        run_frame(5);

        board[199] = 5;
        run_frame(1);
        check("last_x", q_x[199], 416);
        check("last_y", q_y[199], 456);
        check("last_c", q_c[199], 'o700);
        check("a10_x", q_x[10], 200);
        check("a10_y", q_y[10], 24);
        check("a9_x", q_x[9], 416);
        check("a9_y", q_y[9], 0);

        foreach (board[i]) board[i] = 0;
        for (int i = 0; i < 8; i++) board[i] = 3'(i);
        run_frame(2);

        foreach (board[i]) board[i] = 3'($urandom_range(0, 7));
        inject = 1;
        run_frame(int'($urandom_range(2, 6)));
        inject = 0;

        foreach (board[i]) board[i] = 3'($urandom_range(0, 7));
        start_frame(4);
        for (int i = 0; i < 5000 && q_x.size() < 58; i++) @(negedge CLOCK_50);
        check("reached_57", q_x.size(), 58);
        @(negedge CLOCK_50);
        resetn = 0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_addr", bus.rd_addr, 0);
        check("mid_rst_x0", bus.box_x0, OX);
        check("mid_rst_y0", bus.box_y0, OY);
        check("mid_rst_color", bus.box_color, 0);
        repeat (3) @(negedge CLOCK_50);
        check("no_start_in_rst", q_x.size(), 58);
        resetn = 1;
        @(negedge CLOCK_50);
        check("no_start_after_rst", q_x.size(), 58);
        run_frame(int'($urandom_range(1, 5)));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
